// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract unit.
// WIDTH is split into SEGS carry segments, one segment per pipeline stage, with
// the inter-segment carry registered so the critical path is one SW-bit adder.
// Each stage carries the full operand words forward (upper slices still to be
// added) and the partial sum (lower slices already done), which gives the
// operand skew and result de-skew in one uniform structure.
// Optional feature macro: PIPE_ADDER_OVF_EN adds the signed-overflow output ovf.
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int SW = WIDTH / SEGS;

    generate
        if ((SEGS < 1) || (SEGS > WIDTH) || ((WIDTH % SEGS) != 0)) begin : g_bad_params
            $error("pipe_adder: WIDTH must be a multiple of SEGS and 1 <= SEGS <= WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] a_q [SEGS];
    logic [WIDTH-1:0] a_d [SEGS];
    logic [WIDTH-1:0] b_q [SEGS];
    logic [WIDTH-1:0] b_d [SEGS];
    logic [WIDTH-1:0] s_q [SEGS];
    logic [WIDTH-1:0] s_d [SEGS];
    logic [SEGS-1:0]  c_q, c_d;
    logic [SEGS-1:0]  v_q, v_d;
    logic             advance;

    // The whole pipeline moves together; it only freezes when a result is
    // waiting and the consumer refuses it.
    assign advance = !v_q[SEGS-1] || out_ready;

    // Per-stage next state: stage k adds slice k with the carry from stage k-1.
    always_comb begin
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [SW:0]      seg;
        a_src = '0;
        b_src = '0;
        s_src = '0;
        c_src = 1'b0;
        v_src = 1'b0;
        seg   = '0;
        c_d   = '0;
        v_d   = '0;
        for (int k = 0; k < SEGS; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end
        for (int k = 0; k < SEGS; k++) begin
            if (k == 0) begin
                a_src = a;
                b_src = sub ? ~b : b;
                s_src = '0;
                c_src = cin ^ sub;
                v_src = in_valid;
            end else begin
                a_src = a_q[(k > 0) ? k - 1 : 0];
                b_src = b_q[(k > 0) ? k - 1 : 0];
                s_src = s_q[(k > 0) ? k - 1 : 0];
                c_src = c_q[(k > 0) ? k - 1 : 0];
                v_src = v_q[(k > 0) ? k - 1 : 0];
            end
            seg = {1'b0, a_src[k*SW +: SW]} + {1'b0, b_src[k*SW +: SW]} + {{SW{1'b0}}, c_src};
            a_d[k]             = a_src;
            b_d[k]             = b_src;
            s_d[k]             = s_src;
            s_d[k][k*SW +: SW] = seg[SW-1:0];
            c_d[k]             = seg[SW];
            v_d[k]             = v_src;
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Signed overflow, evaluated where the final sum MSB is produced.
    always_comb begin
        ovf_d = (a_d[SEGS-1][WIDTH-1] == b_d[SEGS-1][WIDTH-1]) &&
                (s_d[SEGS-1][WIDTH-1] != a_d[SEGS-1][WIDTH-1]);
    end

    // Overflow flag travels and stalls with the last-stage sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Stage registers: reset discards every in-flight beat, otherwise shift on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SEGS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < SEGS; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    // The last stage's operand copies have no consumer downstream.
    logic unused_last_ops;
    assign unused_last_ops = ^{a_q[SEGS-1], b_q[SEGS-1]};

    assign in_ready  = advance;
    assign out_valid = v_q[SEGS-1];
    assign sum       = s_q[SEGS-1];
    assign cout      = c_q[SEGS-1];

endmodule
